// File: rtl/mcu_spi_pkg.sv
// Shared constants for the MCU SPI target: client ids and FSM state encoding.
`timescale 1ns/1ps
package mcu_spi_pkg;

  // Client ids carried in byte 0 of every frame
  localparam logic [7:0] TARGET_HID = 8'd1;
  localparam logic [7:0] TARGET_OSD = 8'd2;
  localparam logic [7:0] TARGET_SDC = 8'd3;

  // Frame decode state
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_TARGET = 2'd1;
  localparam logic [1:0] ST_CMD    = 2'd2;
  localparam logic [1:0] ST_DATA   = 2'd3;

endpackage

// File: rtl/mcu_spi_target_spi_sync.sv
// Multi-stage synchroniser for one asynchronous SPI pin plus edge detect.
// Ports: clk, reset_n (async active-low), d (raw pin), q (synchronised level),
//        rise_c / fall_c (single-clk edge pulses, combinational from flops).
`timescale 1ns/1ps
module spi_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic [SYNC_STAGES-1:0] chain_d;
  logic                   prev_q;
  logic                   prev_d;

  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], d};
    prev_d  = chain_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q  <= RESET_VAL;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign q      = chain_q[SYNC_STAGES-1];
  assign rise_c = q & ~prev_q;
  assign fall_c = ~q & prev_q;

endmodule

// File: rtl/mcu_spi_target.sv
// SPI mode-0 target: byte 0 of a frame selects the client (target), byte 1 is the
// command (strobed with data_start), later bytes are payload. reply_in is shifted
// out on MISO, one byte per byte slot.
// Ports: clk, reset_n, spi_ss_n/spi_sck/spi_mosi (async inputs), spi_miso,
//        data_out/data_strobe/data_start/target (byte interface), reply_in.
`timescale 1ns/1ps
module mcu_spi_target
  import mcu_spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_ss_n,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [7:0] data_out,
  output logic       data_strobe,
  output logic       data_start,
  output logic [7:0] target,
  input  logic [7:0] reply_in
);

  localparam int unsigned FLUSH_W = $clog2(SYNC_STAGES + 2);
  localparam logic [FLUSH_W-1:0] FLUSH_DONE = FLUSH_W'(SYNC_STAGES + 1);

  logic ss_q, ss_rise_c, ss_fall_c;
  logic sck_rise_c, sck_fall_c, sck_level_unused;
  logic mosi_q, mosi_rise_unused, mosi_fall_unused;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset_n(reset_n), .d(spi_ss_n),
    .q(ss_q), .rise_c(ss_rise_c), .fall_c(ss_fall_c)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk), .reset_n(reset_n), .d(spi_sck),
    .q(sck_level_unused), .rise_c(sck_rise_c), .fall_c(sck_fall_c)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset_n(reset_n), .d(spi_mosi),
    .q(mosi_q), .rise_c(mosi_rise_unused), .fall_c(mosi_fall_unused)
  );

  logic [1:0]         state_q, state_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         rx_q, rx_d;
  logic [7:0]         tx_q, tx_d;
  logic [7:0]         data_out_q, data_out_d;
  logic               strobe_q, strobe_d;
  logic               start_q, start_d;
  logic [7:0]         target_q, target_d;
  logic               armed_q, armed_d;
  logic [FLUSH_W-1:0] flush_q, flush_d;
  logic [7:0]         rx_byte;

  // Frame decode. The synchroniser reset value fakes SS high, so a reset taken
  // while SS is really low would look like an SS fall once the chain flushes;
  // armed_q only opens once SS is seen genuinely high after the flush.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    data_out_d = data_out_q;
    strobe_d   = 1'b0;
    start_d    = start_q;
    target_d   = target_q;
    flush_d    = (flush_q == FLUSH_DONE) ? flush_q : flush_q + FLUSH_W'(1);
    armed_d    = armed_q | ((flush_q == FLUSH_DONE) & ss_q);
    rx_byte    = {rx_q[6:0], mosi_q};

    if (state_q == ST_IDLE) begin
      if (ss_fall_c && armed_q) begin
        state_d   = ST_TARGET;
        bit_cnt_d = 3'd0;
        rx_d      = 8'd0;
        tx_d      = reply_in;
      end
    end else begin
      if (sck_rise_c) begin
        rx_d      = rx_byte;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          tx_d = reply_in;
          case (state_q)
            ST_TARGET: begin
              target_d = rx_byte;
              state_d  = ST_CMD;
            end
            ST_CMD: begin
              data_out_d = rx_byte;
              start_d    = 1'b1;
              strobe_d   = 1'b1;
              state_d    = ST_DATA;
            end
            ST_DATA: begin
              data_out_d = rx_byte;
              start_d    = 1'b0;
              strobe_d   = 1'b1;
            end
            default: ;
          endcase
        end
      end else if (sck_fall_c && (bit_cnt_q != 3'd0)) begin
        // The falling edge right after a byte boundary keeps the freshly loaded MSB.
        tx_d = {tx_q[6:0], 1'b0};
      end
      // SS release wins over the state advance but not over a completing byte.
      if (ss_rise_c) begin
        state_d   = ST_IDLE;
        bit_cnt_d = 3'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      rx_q       <= 8'd0;
      tx_q       <= 8'd0;
      data_out_q <= 8'd0;
      strobe_q   <= 1'b0;
      start_q    <= 1'b0;
      target_q   <= 8'd0;
      armed_q    <= 1'b0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      data_out_q <= data_out_d;
      strobe_q   <= strobe_d;
      start_q    <= start_d;
      target_q   <= target_d;
      armed_q    <= armed_d;
      flush_q    <= flush_d;
    end
  end

  assign spi_miso    = tx_q[7];
  assign data_out    = data_out_q;
  assign data_strobe = strobe_q;
  assign data_start  = start_q;
  assign target      = target_q;

endmodule

// File: tb/tb_mcu_spi_target.sv
// Self-checking bench for mcu_spi_target: frame-level reference model feeds a
// strobe scoreboard; MISO bits are compared as the MCU would sample them.
`timescale 1ns/1ps
module tb_mcu_spi_target;

  localparam int unsigned SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       spi_ss_n;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;
  logic [7:0] data_out;
  logic       data_strobe;
  logic       data_start;
  logic [7:0] target;
  logic [7:0] reply_in;

  typedef struct packed {
    logic [7:0] data;
    logic       start;
    logic [7:0] tgt;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] fb[$];
  logic [7:0] exp_target = 8'd0;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         rise_cyc = 0;
  exp_t       e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mcu_spi_target #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .reset_n(reset_n), .spi_ss_n(spi_ss_n), .spi_sck(spi_sck),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .data_out(data_out),
    .data_strobe(data_strobe), .data_start(data_start), .target(target),
    .reply_in(reply_in)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the next expected byte, 3 clks after bit 7.
  always @(negedge clk) begin
    if (data_strobe === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got data_out=%h start=%b expected no strobe", data_out, data_start);
      end else begin
        e = sb.pop_front();
        chk("strobe_data", 32'(data_out), 32'(e.data));
        chk("strobe_start", 32'(data_start), 32'(e.start));
        chk("strobe_target", 32'(target), 32'(e.tgt));
        chk("strobe_latency", 32'(cyc - rise_cyc), SYNC_STAGES + 1);
      end
    end
  end

  // One byte slot at SCK = clk/8; MISO checked just before each rising edge.
  task automatic send_byte(input logic [7:0] b, input logic [7:0] em, input int nbits, input bit ss_last);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = b[7-i];
      repeat (4) @(negedge clk);
      chk("miso_bit", 32'(spi_miso), 32'(em[7-i]));
      spi_sck  = 1'b1;
      rise_cyc = cyc;
      if (ss_last && (i == nbits - 1)) spi_ss_n = 1'b1;
      repeat (4) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic start_frame(input logic [7:0] rep);
    reply_in = rep;
    spi_ss_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic end_frame();
    repeat (4) @(negedge clk);
    spi_ss_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Model: byte 0 -> target, byte 1 -> start strobe, rest -> payload strobes.
  task automatic run_frame(input int extra_bits, input bit ss_last, input logic [7:0] rep);
    int n;
    n = fb.size();
    for (int k = 1; k < n; k++) sb.push_back('{data: fb[k], start: (k == 1), tgt: fb[0]});
    start_frame(rep);
    for (int k = 0; k < n; k++)
      send_byte(fb[k], rep, 8, ss_last && (k == n - 1) && (extra_bits == 0));
    if (extra_bits > 0) send_byte(8'($urandom), rep, extra_bits, 1'b0);
    end_frame();
    if (n >= 1) exp_target = fb[0];
    chk("frame_target", 32'(target), 32'(exp_target));
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data_out"}, 32'(data_out), 32'd0);
    chk({tag, "_strobe"}, 32'(data_strobe), 32'd0);
    chk({tag, "_start"}, 32'(data_start), 32'd0);
    chk({tag, "_target"}, 32'(target), 32'd0);
    chk({tag, "_miso"}, 32'(spi_miso), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int extra;
    bit ssl;
    reset_n  = 1'b0;
    spi_ss_n = 1'b1;
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    reply_in = 8'd0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    fb = '{8'h02, 8'h01, 8'h01};
    run_frame(0, 1'b0, 8'h3C);
    fb = '{8'h02, 8'h02, 8'h05, 8'hAA, 8'h55};
    run_frame(0, 1'b0, 8'hA5);
    // SS released 5 bits into a byte: partial byte dropped
    fb = '{8'h03, 8'h07};
    run_frame(5, 1'b0, 8'h5A);
    fb = '{8'h02, 8'h01, 8'h00};
    run_frame(0, 1'b0, 8'($urandom));
    // SS rises together with the 8th SCK edge
    fb = '{8'h01, 8'hC3, 8'h3C};
    run_frame(0, 1'b1, 8'h81);
    // Target-only frame
    fb = '{8'h02};
    run_frame(0, 1'b0, 8'h0F);

    // SCK activity with SS high is ignored
    for (int i = 0; i < 16; i++) begin
      spi_mosi = 1'($urandom);
      repeat (4) @(negedge clk);
      spi_sck = ~spi_sck;
    end
    repeat (8) @(negedge clk);
    chk("ss_high_target", 32'(target), 32'(exp_target));

    // Reset in the middle of a payload byte
    sb.push_back('{data: 8'h0A, start: 1'b1, tgt: 8'h03});
    start_frame(8'h66);
    send_byte(8'h03, 8'h66, 8, 1'b0);
    send_byte(8'h0A, 8'h66, 8, 1'b0);
    send_byte(8'hF0, 8'h66, 3, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    exp_target = 8'd0;
    @(negedge clk);
    reset_n = 1'b1;
    send_byte(8'h02, 8'h00, 8, 1'b0);
    send_byte(8'h77, 8'h00, 8, 1'b0);
    end_frame();
    chk("postreset_target", 32'(target), 32'd0);
    chk("postreset_sb", 32'(sb.size()), 32'd0);
    fb = '{8'h02, 8'h11, 8'h22};
    run_frame(0, 1'b0, 8'hC5);

    // Randomised frames
    for (int r = 0; r < 12; r++) begin
      n = 1 + int'($urandom % 6);
      fb.delete();
      fb.push_back((r % 2 == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom));
      for (int k = 1; k < n; k++) fb.push_back(8'($urandom));
      extra = ($urandom % 3 == 0) ? int'($urandom_range(1, 7)) : 0;
      ssl   = (extra == 0) && ($urandom % 2 == 1);
      run_frame(extra, ssl, 8'($urandom));
    end

    repeat (20) @(negedge clk);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
